id_ex_latch: RTL and testbench
==============================

ID_EX_LATCH -- requirements
Module: id_ex_latch

Interface
REQ-001 Parameters: NB_DATA=32, data word width; NB_OPCODE=6, opcode width; NB_FCODE=6, funct width; NB_REG=5, register address/shamt width; NB_CNT=16, bubble counter width.
REQ-002 i_clk  in  1  single clock; all state updates on rising edge.
REQ-003 i_reset_n  in  1  synchronous, active-low reset, sampled on i_clk rising edge.
REQ-004 i_step  in  1  pipeline advance enable (debug step/run); 0 = freeze all state.
REQ-005 i_stall  in  1  load-use hazard from hazard unit; insert bubble.
REQ-006 i_flush  in  1  branch-taken flush; insert bubble.
REQ-007 i_valid  in  1  decode stage holds a real instruction.
REQ-008 i_opcode / i_funct  in  NB_OPCODE / NB_FCODE  decoded instruction fields.
REQ-009 i_rs_addr, i_rt_addr, i_rd_addr, i_shamt  in  NB_REG each  register addresses and shift amount.
REQ-010 i_rs_data, i_rt_data, i_imm_ext, i_pc4  in  NB_DATA each  register-file reads, sign-extended immediate, PC+4.
REQ-011 i_reg_write, i_mem_read, i_mem_write, i_mem_to_reg, i_alu_src, i_reg_dst, i_branch  in  1 each  control unit outputs.
REQ-012 i_wb_reg_write  in  1, i_wb_addr  in  NB_REG, i_wb_data  in  NB_DATA  write-back port for same-cycle bypass.
REQ-013 o_* outputs: one registered output per REQ-008..REQ-011 input, same name with o_ prefix and same width, plus o_valid  out  1.
REQ-014 o_bubble_count  out  NB_CNT  number of bubbles inserted since reset.

Function
REQ-015 Priority each edge: reset > (i_step==0: hold) > i_flush > i_stall > load.
REQ-016 Hold: i_step=0 keeps every register, including o_bubble_count, unchanged, regardless of i_flush/i_stall/i_valid.
REQ-017 Load (i_step=1, i_flush=0, i_stall=0): all o_* take their i_* values one cycle later; o_valid = i_valid; latency exactly 1 cycle.
REQ-018 Bubble (i_step=1 with i_flush=1 or i_stall=1): o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg, o_alu_src, o_reg_dst, o_branch = 0; o_valid=0; o_opcode=6'h00, o_funct=6'h00 (sll $0,$0,0, i.e. NOP); all address, shamt and data outputs = 0.
REQ-019 Simultaneous i_flush and i_stall produce exactly one bubble and one counter increment.
REQ-020 Bubble counter increments by 1 per bubble cycle; saturates at 2^NB_CNT-1 (no wrap).
REQ-021 Bypass on load: if i_wb_reg_write=1, i_wb_addr!=0 and i_wb_addr==i_rs_addr, o_rs_data captures i_wb_data instead of i_rs_data; same rule independently for rt.
REQ-022 Bypass never applies for register 0; bypass is inactive on bubble and hold cycles.
REQ-023 i_valid=0 on a load cycle captures all fields unchanged but o_valid=0; control outputs are loaded as presented (no forced zeroing).
REQ-024 Outputs are purely registered; no combinational path from any input to any output.

Reset
REQ-025 i_reset_n=0 at a rising edge sets every output to 0 (including o_opcode, o_funct, o_valid, o_bubble_count) on that edge, overriding i_step, i_flush, i_stall.
REQ-026 Reset asserted mid-operation discards the held instruction; first edge after i_reset_n=1 with i_step=1 behaves per REQ-015..REQ-023.

Verification
REQ-027 Reset: drive random inputs, i_reset_n=0 for 2 cycles -> all outputs 0, o_bubble_count=0.
REQ-028 Load: i_step=1, opcode=6'h23 (lw), rs_data=32'h0000_0010, imm=32'h4, mem_read=1 -> next edge o_opcode=6'h23, o_mem_read=1, o_rs_data=32'h10, o_imm_ext=32'h4, o_valid=1.
REQ-029 Hold/flush: load add (funct 6'h20, reg_write=1), then i_step=0 with i_flush=1 for 3 cycles -> outputs unchanged, counter unchanged; then i_step=1, i_flush=1 -> o_reg_write=0, o_funct=0, o_valid=0, counter=1.
REQ-030 Bypass: i_rs_addr=5'd8, i_rs_data=32'h1111_1111, i_wb_reg_write=1, i_wb_addr=5'd8, i_wb_data=32'hDEAD_BEEF -> o_rs_data=32'hDEAD_BEEF; repeat with both addresses 0 -> o_rs_data=32'h1111_1111.
REQ-031 Stall+flush: i_stall=1 and i_flush=1 same cycle -> one bubble, counter +1 (not +2).
REQ-032 Saturation: force 65540 bubble cycles -> o_bubble_count stays 16'hFFFF.

Source files
------------

// File: rtl/id_ex_latch_if.sv
// ID/EX pipeline-register bundle: decode-side fields in (i_*), registered execute-side fields out (o_*).
// master = decode/hazard side, slave = the latch itself.
interface id_ex_latch_if #(
  parameter int NB_DATA   = 32,
  parameter int NB_OPCODE = 6,
  parameter int NB_FCODE  = 6,
  parameter int NB_REG    = 5,
  parameter int NB_CNT    = 16
);
  logic                 i_step;
  logic                 i_stall;
  logic                 i_flush;
  logic                 i_valid;
  logic [NB_OPCODE-1:0] i_opcode;
  logic [NB_FCODE-1:0]  i_funct;
  logic [NB_REG-1:0]    i_rs_addr;
  logic [NB_REG-1:0]    i_rt_addr;
  logic [NB_REG-1:0]    i_rd_addr;
  logic [NB_REG-1:0]    i_shamt;
  logic [NB_DATA-1:0]   i_rs_data;
  logic [NB_DATA-1:0]   i_rt_data;
  logic [NB_DATA-1:0]   i_imm_ext;
  logic [NB_DATA-1:0]   i_pc4;
  logic                 i_reg_write;
  logic                 i_mem_read;
  logic                 i_mem_write;
  logic                 i_mem_to_reg;
  logic                 i_alu_src;
  logic                 i_reg_dst;
  logic                 i_branch;
  logic                 i_wb_reg_write;
  logic [NB_REG-1:0]    i_wb_addr;
  logic [NB_DATA-1:0]   i_wb_data;

  logic                 o_valid;
  logic [NB_OPCODE-1:0] o_opcode;
  logic [NB_FCODE-1:0]  o_funct;
  logic [NB_REG-1:0]    o_rs_addr;
  logic [NB_REG-1:0]    o_rt_addr;
  logic [NB_REG-1:0]    o_rd_addr;
  logic [NB_REG-1:0]    o_shamt;
  logic [NB_DATA-1:0]   o_rs_data;
  logic [NB_DATA-1:0]   o_rt_data;
  logic [NB_DATA-1:0]   o_imm_ext;
  logic [NB_DATA-1:0]   o_pc4;
  logic                 o_reg_write;
  logic                 o_mem_read;
  logic                 o_mem_write;
  logic                 o_mem_to_reg;
  logic                 o_alu_src;
  logic                 o_reg_dst;
  logic                 o_branch;
  logic [NB_CNT-1:0]    o_bubble_count;

  modport master (
    output i_step, i_stall, i_flush, i_valid, i_opcode, i_funct,
           i_rs_addr, i_rt_addr, i_rd_addr, i_shamt,
           i_rs_data, i_rt_data, i_imm_ext, i_pc4,
           i_reg_write, i_mem_read, i_mem_write, i_mem_to_reg,
           i_alu_src, i_reg_dst, i_branch,
           i_wb_reg_write, i_wb_addr, i_wb_data,
    input  o_valid, o_opcode, o_funct, o_rs_addr, o_rt_addr, o_rd_addr, o_shamt,
           o_rs_data, o_rt_data, o_imm_ext, o_pc4,
           o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg,
           o_alu_src, o_reg_dst, o_branch, o_bubble_count
  );

  modport slave (
    input  i_step, i_stall, i_flush, i_valid, i_opcode, i_funct,
           i_rs_addr, i_rt_addr, i_rd_addr, i_shamt,
           i_rs_data, i_rt_data, i_imm_ext, i_pc4,
           i_reg_write, i_mem_read, i_mem_write, i_mem_to_reg,
           i_alu_src, i_reg_dst, i_branch,
           i_wb_reg_write, i_wb_addr, i_wb_data,
    output o_valid, o_opcode, o_funct, o_rs_addr, o_rt_addr, o_rd_addr, o_shamt,
           o_rs_data, o_rt_data, o_imm_ext, o_pc4,
           o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg,
           o_alu_src, o_reg_dst, o_branch, o_bubble_count
  );
endinterface

// File: rtl/id_ex_latch.sv
// ID/EX pipeline register with write-back bypass and saturating bubble counter; 1-cycle latency.
// i_step=0 freezes everything; flush/stall load an all-zero NOP bubble instead of the decode fields.
module id_ex_latch #(
  parameter int NB_DATA   = 32,
  parameter int NB_OPCODE = 6,
  parameter int NB_FCODE  = 6,
  parameter int NB_REG    = 5,
  parameter int NB_CNT    = 16
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  id_ex_latch_if.slave  bus
);

  typedef struct packed {
    logic                 valid;
    logic [NB_OPCODE-1:0] opcode;
    logic [NB_FCODE-1:0]  funct;
    logic [NB_REG-1:0]    rs_addr;
    logic [NB_REG-1:0]    rt_addr;
    logic [NB_REG-1:0]    rd_addr;
    logic [NB_REG-1:0]    shamt;
    logic [NB_DATA-1:0]   rs_data;
    logic [NB_DATA-1:0]   rt_data;
    logic [NB_DATA-1:0]   imm_ext;
    logic [NB_DATA-1:0]   pc4;
    logic                 reg_write;
    logic                 mem_read;
    logic                 mem_write;
    logic                 mem_to_reg;
    logic                 alu_src;
    logic                 reg_dst;
    logic                 branch;
  } stage_t;

  stage_t            r_stage;
  logic [NB_CNT-1:0] r_bubble_count;
  stage_t            w_load;
  logic              w_bubble;
  logic              w_rs_fwd;
  logic              w_rt_fwd;

  assign w_bubble = bus.i_flush | bus.i_stall;

  // $0 is hard-wired zero, so a write-back targeting it must never be forwarded.
  assign w_rs_fwd = bus.i_wb_reg_write && (bus.i_wb_addr != '0) && (bus.i_wb_addr == bus.i_rs_addr);
  assign w_rt_fwd = bus.i_wb_reg_write && (bus.i_wb_addr != '0) && (bus.i_wb_addr == bus.i_rt_addr);

  always_comb begin
    w_load            = '0;
    w_load.valid      = bus.i_valid;
    w_load.opcode     = bus.i_opcode;
    w_load.funct      = bus.i_funct;
    w_load.rs_addr    = bus.i_rs_addr;
    w_load.rt_addr    = bus.i_rt_addr;
    w_load.rd_addr    = bus.i_rd_addr;
    w_load.shamt      = bus.i_shamt;
    w_load.rs_data    = w_rs_fwd ? bus.i_wb_data : bus.i_rs_data;
    w_load.rt_data    = w_rt_fwd ? bus.i_wb_data : bus.i_rt_data;
    w_load.imm_ext    = bus.i_imm_ext;
    w_load.pc4        = bus.i_pc4;
    w_load.reg_write  = bus.i_reg_write;
    w_load.mem_read   = bus.i_mem_read;
    w_load.mem_write  = bus.i_mem_write;
    w_load.mem_to_reg = bus.i_mem_to_reg;
    w_load.alu_src    = bus.i_alu_src;
    w_load.reg_dst    = bus.i_reg_dst;
    w_load.branch     = bus.i_branch;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_stage        <= '0;
      r_bubble_count <= '0;
    end else if (bus.i_step) begin
      if (w_bubble) begin
        // All-zero stage encodes sll $0,$0,0 with every control bit cleared.
        r_stage <= '0;
        if (r_bubble_count != {NB_CNT{1'b1}}) begin
          r_bubble_count <= r_bubble_count + NB_CNT'(1);
        end
      end else begin
        r_stage <= w_load;
      end
    end
  end

  assign bus.o_valid        = r_stage.valid;
  assign bus.o_opcode       = r_stage.opcode;
  assign bus.o_funct        = r_stage.funct;
  assign bus.o_rs_addr      = r_stage.rs_addr;
  assign bus.o_rt_addr      = r_stage.rt_addr;
  assign bus.o_rd_addr      = r_stage.rd_addr;
  assign bus.o_shamt        = r_stage.shamt;
  assign bus.o_rs_data      = r_stage.rs_data;
  assign bus.o_rt_data      = r_stage.rt_data;
  assign bus.o_imm_ext      = r_stage.imm_ext;
  assign bus.o_pc4          = r_stage.pc4;
  assign bus.o_reg_write    = r_stage.reg_write;
  assign bus.o_mem_read     = r_stage.mem_read;
  assign bus.o_mem_write    = r_stage.mem_write;
  assign bus.o_mem_to_reg   = r_stage.mem_to_reg;
  assign bus.o_alu_src      = r_stage.alu_src;
  assign bus.o_reg_dst      = r_stage.reg_dst;
  assign bus.o_branch       = r_stage.branch;
  assign bus.o_bubble_count = r_bubble_count;

endmodule

// File: tb/tb_id_ex_latch.sv
// Directed bench for id_ex_latch: reset, load, hold, flush/stall bubbles, bypass, saturation.
module tb_id_ex_latch;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  id_ex_latch_if u_if ();

  id_ex_latch u_dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    u_if.i_step = 1'b1;       u_if.i_stall = 1'b0;     u_if.i_flush = 1'b0;
    u_if.i_valid = 1'b1;      u_if.i_opcode = '0;      u_if.i_funct = '0;
    u_if.i_rs_addr = '0;      u_if.i_rt_addr = '0;     u_if.i_rd_addr = '0;
    u_if.i_shamt = '0;        u_if.i_rs_data = '0;     u_if.i_rt_data = '0;
    u_if.i_imm_ext = '0;      u_if.i_pc4 = '0;         u_if.i_reg_write = 1'b0;
    u_if.i_mem_read = 1'b0;   u_if.i_mem_write = 1'b0; u_if.i_mem_to_reg = 1'b0;
    u_if.i_alu_src = 1'b0;    u_if.i_reg_dst = 1'b0;   u_if.i_branch = 1'b0;
    u_if.i_wb_reg_write = 1'b0; u_if.i_wb_addr = '0;   u_if.i_wb_data = '0;
  endtask

  task automatic random_inputs();
    u_if.i_step = 1'b1;               u_if.i_stall = 1'($urandom);  u_if.i_flush = 1'($urandom);
    u_if.i_valid = 1'b1;              u_if.i_opcode = 6'($urandom); u_if.i_funct = 6'($urandom);
    u_if.i_rs_addr = 5'($urandom);    u_if.i_rt_addr = 5'($urandom); u_if.i_rd_addr = 5'($urandom);
    u_if.i_shamt = 5'($urandom);      u_if.i_rs_data = $urandom;    u_if.i_rt_data = $urandom;
    u_if.i_imm_ext = $urandom;        u_if.i_pc4 = $urandom;        u_if.i_reg_write = 1'b1;
    u_if.i_mem_read = 1'b1;           u_if.i_mem_write = 1'b1;      u_if.i_mem_to_reg = 1'b1;
    u_if.i_alu_src = 1'b1;            u_if.i_reg_dst = 1'b1;        u_if.i_branch = 1'b1;
    u_if.i_wb_reg_write = 1'b1;       u_if.i_wb_addr = 5'($urandom); u_if.i_wb_data = $urandom;
  endtask

  function automatic logic any_out();
    return |{u_if.o_valid, u_if.o_opcode, u_if.o_funct, u_if.o_rs_addr, u_if.o_rt_addr,
             u_if.o_rd_addr, u_if.o_shamt, u_if.o_rs_data, u_if.o_rt_data, u_if.o_imm_ext,
             u_if.o_pc4, u_if.o_reg_write, u_if.o_mem_read, u_if.o_mem_write,
             u_if.o_mem_to_reg, u_if.o_alu_src, u_if.o_reg_dst, u_if.o_branch,
             u_if.o_bubble_count};
  endfunction

  initial begin
    n_cmp = 0;
    n_err = 0;

    // Reset with random inputs for two cycles
    rst_n = 1'b0;
    random_inputs();
    tick();
    random_inputs();
    tick();
    check("rst_any_out", 64'(any_out()), 64'd0);
    check("rst_opcode", 64'(u_if.o_opcode), 64'd0);
    check("rst_count", 64'(u_if.o_bubble_count), 64'd0);

    // lw load, 1-cycle latency
    rst_n = 1'b1;
    idle_inputs();
    u_if.i_opcode = 6'h23; u_if.i_rs_data = 32'h0000_0010; u_if.i_imm_ext = 32'h4;
    u_if.i_mem_read = 1'b1; u_if.i_rt_addr = 5'd9; u_if.i_pc4 = 32'h0000_0104;
    tick();
    check("lw_opcode", 64'(u_if.o_opcode), 64'h23);
    check("lw_mem_read", 64'(u_if.o_mem_read), 64'd1);
    check("lw_rs_data", 64'(u_if.o_rs_data), 64'h10);
    check("lw_imm", 64'(u_if.o_imm_ext), 64'h4);
    check("lw_valid", 64'(u_if.o_valid), 64'd1);
    check("lw_rt_addr", 64'(u_if.o_rt_addr), 64'd9);
    check("lw_pc4", 64'(u_if.o_pc4), 64'h104);

    // add, then hold with flush asserted: nothing moves
    idle_inputs();
    u_if.i_funct = 6'h20; u_if.i_reg_write = 1'b1; u_if.i_rd_addr = 5'd3; u_if.i_reg_dst = 1'b1;
    tick();
    check("add_funct", 64'(u_if.o_funct), 64'h20);
    u_if.i_step = 1'b0; u_if.i_flush = 1'b1; u_if.i_funct = 6'h22; u_if.i_rd_addr = 5'd7;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_funct", 64'(u_if.o_funct), 64'h20);
      check("hold_reg_write", 64'(u_if.o_reg_write), 64'd1);
      check("hold_rd_addr", 64'(u_if.o_rd_addr), 64'd3);
      check("hold_count", 64'(u_if.o_bubble_count), 64'd0);
    end
    u_if.i_step = 1'b1;
    tick();
    check("flush_reg_write", 64'(u_if.o_reg_write), 64'd0);
    check("flush_funct", 64'(u_if.o_funct), 64'd0);
    check("flush_valid", 64'(u_if.o_valid), 64'd0);
    check("flush_any_out_but_cnt", 64'(any_out() && (u_if.o_bubble_count != 16'd1)), 64'd0);
    check("flush_count", 64'(u_if.o_bubble_count), 64'd1);

    // Bypass rs only, then rs and rt, then register 0 never forwarded
    idle_inputs();
    u_if.i_rs_addr = 5'd8; u_if.i_rs_data = 32'h1111_1111;
    u_if.i_rt_addr = 5'd9; u_if.i_rt_data = 32'h2222_2222;
    u_if.i_wb_reg_write = 1'b1; u_if.i_wb_addr = 5'd8; u_if.i_wb_data = 32'hDEAD_BEEF;
    tick();
    check("byp_rs", 64'(u_if.o_rs_data), 64'hDEAD_BEEF);
    check("byp_rt_nomatch", 64'(u_if.o_rt_data), 64'h2222_2222);
    u_if.i_rt_addr = 5'd8;
    tick();
    check("byp_rt", 64'(u_if.o_rt_data), 64'hDEAD_BEEF);
    u_if.i_wb_reg_write = 1'b0;
    tick();
    check("byp_no_we", 64'(u_if.o_rs_data), 64'h1111_1111);
    u_if.i_wb_reg_write = 1'b1; u_if.i_rs_addr = 5'd0; u_if.i_wb_addr = 5'd0;
    tick();
    check("byp_r0", 64'(u_if.o_rs_data), 64'h1111_1111);

    // Bypass inactive on a stall bubble
    u_if.i_rs_addr = 5'd8; u_if.i_wb_addr = 5'd8; u_if.i_stall = 1'b1;
    tick();
    check("stall_rs_data", 64'(u_if.o_rs_data), 64'd0);
    check("stall_count", 64'(u_if.o_bubble_count), 64'd2);

    // Stall and flush together count once
    u_if.i_flush = 1'b1;
    tick();
    check("stfl_count", 64'(u_if.o_bubble_count), 64'd3);

    // Hold with stall: counter frozen
    u_if.i_step = 1'b0;
    tick();
    check("hold_stall_count", 64'(u_if.o_bubble_count), 64'd3);

    // valid=0 load keeps control bits as presented
    idle_inputs();
    u_if.i_valid = 1'b0; u_if.i_reg_write = 1'b1; u_if.i_mem_write = 1'b1; u_if.i_opcode = 6'h2B;
    tick();
    check("inv_valid", 64'(u_if.o_valid), 64'd0);
    check("inv_reg_write", 64'(u_if.o_reg_write), 64'd1);
    check("inv_mem_write", 64'(u_if.o_mem_write), 64'd1);
    check("inv_opcode", 64'(u_if.o_opcode), 64'h2B);

    // Mid-operation reset discards the instruction, then next load works
    rst_n = 1'b0; u_if.i_step = 1'b0;
    tick();
    check("rst_mid_any", 64'(any_out()), 64'd0);
    rst_n = 1'b1; u_if.i_step = 1'b1; u_if.i_valid = 1'b1; u_if.i_opcode = 6'h04; u_if.i_branch = 1'b1;
    tick();
    check("post_rst_opcode", 64'(u_if.o_opcode), 64'h04);
    check("post_rst_branch", 64'(u_if.o_branch), 64'd1);

    // Saturation after 65540 bubbles
    u_if.i_stall = 1'b1;
    for (int i = 0; i < 65540; i++) tick();
    check("sat_count", 64'(u_if.o_bubble_count), 64'hFFFF);
    tick();
    check("sat_hold", 64'(u_if.o_bubble_count), 64'hFFFF);
    rst_n = 1'b0;
    tick();
    check("sat_rst", 64'(u_if.o_bubble_count), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
